cpu_tx_buffer: RTL
==================

Name: cpu_tx_buffer

Overview:
Per-CPU egress buffer between a CPU traffic source and one NOC input port. It stores CPU words in a small circular FIFO and presents them on a vld/rdy interface to the NOC. It caps the stream at TRANSACTION_NB accepted words and flags completion once all of them have been delivered. One instance is used per CPU, indexed like the NOC's per-CPU ports.

Parameters:
DEPTH, 4, FIFO entries; legal range 2..16, any integer (not restricted to powers of 2).
DATA_W, 64, data width in bits.
TRANSACTION_NB, 1000, words accepted and delivered before done; must be >= 1.

Ports:
clk  input  1  single clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
in_vld  input  1  CPU word valid.
in_rdy  output  1  buffer can accept a word this cycle.
in_data  input  DATA_W  CPU word.
out_vld  output  1  word available to NOC.
out_rdy  input  1  NOC ready (may toggle every cycle).
out_data  output  DATA_W  head-of-FIFO word.
count  output  $clog2(DEPTH+1)  current occupancy.
sent_cnt  output  32  words delivered to NOC.
done  output  1  sticky; all TRANSACTION_NB words delivered.

Behaviour:
- Reset values: count=0, sent_cnt=0, done=0, out_vld=0, in_rdy=0 while rst is high. Read/write pointers reset to 0. accepted counter (internal, 32b) resets to 0. out_data resets to 0.
- Accept: push occurs when in_vld && in_rdy at posedge. Entry written at wr_ptr; wr_ptr advances; accepted increments.
- in_rdy = !rst && (count < DEPTH) && (accepted < TRANSACTION_NB). Derived combinationally from registered state only, never from out_rdy.
- No full bypass: when count==DEPTH, in_rdy=0 even if a pop happens in the same cycle.
- Deliver: pop occurs when out_vld && out_rdy at posedge. rd_ptr advances; sent_cnt increments.
- out_vld = (count != 0). out_data = mem[rd_ptr]. Both are stable while out_vld && !out_rdy.
- Latency: a word pushed at edge N is visible on out_vld/out_data after edge N, i.e. it can be popped at edge N+1 at the earliest. No same-cycle pass-through.
- Pointer wrap: each pointer goes from DEPTH-1 to 0. The full/empty decision uses count, not pointer comparison.
- Simultaneous push and pop (possible only when 0 < count < DEPTH): count is unchanged and both pointers advance.
- Push into empty with no pop: count goes 0 to 1.
- Pop of the last entry together with a push: count stays 1 and out_vld stays 1.
- Stream cap: once accepted==TRANSACTION_NB, in_rdy stays 0 permanently until reset. Remaining entries continue to drain.
- done: set at the edge on which sent_cnt transitions to TRANSACTION_NB. It stays set until reset. After done, count=0 and out_vld=0.
- Reset mid-operation: all buffered words are discarded and every counter clears immediately (asynchronous). Outputs follow the reset values within the same cycle.
- State summary (implicit FSM): EMPTY(count=0) -> PARTIAL -> FULL(count=DEPTH) -> PARTIAL -> EMPTY. CAPPED is an orthogonal flag (accepted==TRANSACTION_NB). DONE = CAPPED && EMPTY && sent_cnt==TRANSACTION_NB.

Test Plan:
1. Reset then stream, DEPTH=4, TRANSACTION_NB=8, in_vld=1, out_rdy=1 always, data 0x1..0x8 -> out_data order 0x1..0x8. First out_vld comes one cycle after the first push. done=1 after the 8th pop. in_rdy=0 after the 8th push.
2. Fill: out_rdy=0, push 0xA0..0xA5 -> 4 accepted, count=4, in_rdy=0. Then out_rdy=1 for one cycle -> 0xA0 popped and count=3. in_rdy=1 only on the following cycle.
3. Wrap: DEPTH=3, random out_rdy at 50%, 20 words with data=index -> 20 words received in order, no loss or duplicate, count never >3.
4. Backpressure stability: out_vld=1, out_rdy=0 for 5 cycles -> out_data constant and sent_cnt unchanged.
5. Async reset mid-stream: assert rst between edges with count=2, sent_cnt=3 -> count=0, sent_cnt=0, out_vld=0, in_rdy=0 immediately. After release, the stream restarts from word 1.
6. Cap: TRANSACTION_NB=1, in_vld held high with 0x55 -> exactly one push, in_rdy=0 forever. done=1 at the edge after the pop, sent_cnt=1.

Source files
------------

// File: rtl/cpu_tx_buffer.sv
// Generic circular FIFO with occupancy count; storage clears on reset.
// Latency: a word written at edge N is readable on rd_dat after edge N (no fall-through).
// Backpressure: none internally; the caller never writes when full nor reads when empty.
module fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_vld,
    output logic [W-1:0]  rd_dat,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage: cleared on reset so the head word reads zero until the first write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_vld) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers and occupancy; full/empty is judged from count, never from pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (rd_vld) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (wr_vld && !rd_vld) begin
                count <= count + CW'(1);
            end else if (!wr_vld && rd_vld) begin
                count <= count - CW'(1);
            end
        end
    end

    assign rd_dat = mem[rd_ptr];

endmodule

// Per-CPU egress buffer: queues CPU words for one NOC port, caps the stream, flags completion.
// Latency: one cycle from accept to out_vld; no same-cycle pass-through.
// Backpressure: in_rdy drops when full (no bypass on simultaneous pop) or once the cap is reached; out side holds while !out_rdy.
module cpu_tx_buffer #(
    parameter int DEPTH          = 4,
    parameter int DATA_W         = 64,
    parameter int TRANSACTION_NB = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [31:0]                  sent_cnt,
    output logic                         done
);
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] TNB = 32'(TRANSACTION_NB);

    logic        push;
    logic        pop;
    logic [31:0] accepted;

    // Readiness depends only on registered state, never on out_rdy.
    assign in_rdy  = !rst && (count < CW'(DEPTH)) && (accepted < TNB);
    assign out_vld = (count != '0);
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;

    fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_W),
        .CW    (CW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push),
        .wr_dat (in_data),
        .rd_vld (pop),
        .rd_dat (out_data),
        .count  (count)
    );

    // Stream accounting: accepted/delivered word counters and the sticky done flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accepted <= '0;
            sent_cnt <= '0;
            done     <= 1'b0;
        end else begin
            if (push) begin
                accepted <= accepted + 32'd1;
            end
            if (pop) begin
                sent_cnt <= sent_cnt + 32'd1;
                if (sent_cnt == TNB - 32'd1) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule
